// File: rtl/bcd_key_entry.sv
// Keypad digit collector feeding the BCD-to-binary converter: builds a packed-BCD
// operand, launches a conversion on ENTER, captures the result or times out.
// Optional BACKSPACE support is enabled with `define KEY_BACKSPACE_EN.
module bcd_key_entry #(
  parameter int MAX_DIGITS   = 4,
  parameter int CONV_TIMEOUT = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               key_valid,
  input  logic [3:0]                         key_code,
  output logic [4*MAX_DIGITS-1:0]            bcd_word,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_count,
  output logic                               conv_start,
  input  logic                               conv_done,
  input  logic [15:0]                        conv_result,
  output logic [15:0]                        bin_value,
  output logic                               result_valid,
  output logic                               busy,
  output logic                               overflow,
  output logic                               timeout_err
);

  localparam int BW = 4 * MAX_DIGITS;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(CONV_TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
  localparam logic [TW-1:0] T_LAST  = TW'(CONV_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_ENTRY = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [BW-1:0]   r_bcd, w_bcd_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [15:0]     r_bin, w_bin_nxt;
  logic [TW-1:0]   r_tmr, w_tmr_nxt;
  logic            r_start, w_start_nxt;
  logic            r_rv, w_rv_nxt;
  logic            r_ovf, w_ovf_nxt;
  logic            r_to, w_to_nxt;
  logic            w_is_digit;

  assign w_is_digit = (key_code <= 4'd9);

  always_comb begin
    w_state_nxt = r_state;
    w_bcd_nxt   = r_bcd;
    w_cnt_nxt   = r_cnt;
    w_bin_nxt   = r_bin;
    w_tmr_nxt   = r_tmr;
    w_start_nxt = 1'b0;
    w_rv_nxt    = 1'b0;
    w_ovf_nxt   = 1'b0;
    w_to_nxt    = 1'b0;
    case (r_state)
      S_ENTRY: begin
        if (key_valid) begin
          if (w_is_digit) begin
            if (r_cnt < MAX_CNT) begin
              w_bcd_nxt = {r_bcd[BW-5:0], key_code};
              w_cnt_nxt = r_cnt + CW'(1);
            end else begin
              w_ovf_nxt = 1'b1;
            end
          end else begin
            case (key_code)
              4'hA: begin
                if (r_cnt != '0) begin
                  w_state_nxt = S_START;
                  w_start_nxt = 1'b1;
                end
              end
              4'hB: begin
                w_bcd_nxt = '0;
                w_cnt_nxt = '0;
              end
`ifdef KEY_BACKSPACE_EN
              4'hC: begin
                if (r_cnt != '0) begin
                  w_bcd_nxt = {4'h0, r_bcd[BW-1:4]};
                  w_cnt_nxt = r_cnt - CW'(1);
                end
              end
`else
              4'hC: ;
`endif
              default: ;
            endcase
          end
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT;
        w_tmr_nxt   = '0;
      end
      S_WAIT: begin
        // done is checked first so it wins over a coincident timeout expiry
        if (conv_done) begin
          w_bin_nxt   = conv_result;
          w_rv_nxt    = 1'b1;
          w_bcd_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_ENTRY;
        end else if (r_tmr == T_LAST) begin
          w_to_nxt    = 1'b1;
          w_state_nxt = S_ENTRY;
        end else begin
          w_tmr_nxt = r_tmr + TW'(1);
        end
      end
      default: w_state_nxt = S_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_ENTRY;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_tmr   <= '0;
      r_start <= 1'b0;
      r_rv    <= 1'b0;
      r_ovf   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bcd   <= w_bcd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bin   <= w_bin_nxt;
      r_tmr   <= w_tmr_nxt;
      r_start <= w_start_nxt;
      r_rv    <= w_rv_nxt;
      r_ovf   <= w_ovf_nxt;
      r_to    <= w_to_nxt;
    end
  end

  assign bcd_word     = r_bcd;
  assign digit_count  = r_cnt;
  assign conv_start   = r_start;
  assign bin_value    = r_bin;
  assign result_valid = r_rv;
  assign overflow     = r_ovf;
  assign timeout_err  = r_to;
  assign busy         = (r_state != S_ENTRY);

endmodule

// File: tb/tb_bcd_key_entry.sv
// Directed bench for bcd_key_entry: per-cycle vector table plus timeout and reset sequences.
module tb_bcd_key_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] bcd_word;
  logic [2:0]  digit_count;
  logic        conv_start;
  logic        conv_done;
  logic [15:0] conv_result;
  logic [15:0] bin_value;
  logic        result_valid;
  logic        busy;
  logic        overflow;
  logic        timeout_err;

  int n_chk = 0;
  int n_err = 0;

  bcd_key_entry #(.MAX_DIGITS(4), .CONV_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .bcd_word(bcd_word), .digit_count(digit_count), .conv_start(conv_start),
    .conv_done(conv_done), .conv_result(conv_result), .bin_value(bin_value),
    .result_valid(result_valid), .busy(busy), .overflow(overflow),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic        dn;
    logic [15:0] rs;
    logic [15:0] bcd;
    logic [2:0]  cnt;
    logic        st;
    logic        bz;
    logic        rv;
    logic        ov;
    logic        to;
    logic [15:0] bin;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic kv, logic [3:0] kc, logic dn, logic [15:0] rs,
                              logic [15:0] bcd, logic [2:0] cnt, logic st, logic bz,
                              logic rv, logic ov, logic to, logic [15:0] bin);
    vec_t v;
    v.kv = kv; v.kc = kc; v.dn = dn; v.rs = rs; v.bcd = bcd; v.cnt = cnt;
    v.st = st; v.bz = bz; v.rv = rv; v.ov = ov; v.to = to; v.bin = bin;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] bcd, input logic [2:0] cnt,
                            input logic st, input logic bz, input logic rv, input logic ov,
                            input logic to, input logic [15:0] bin);
    chk({tag, ".bcd_word"}, 32'(bcd_word), 32'(bcd));
    chk({tag, ".digit_count"}, 32'(digit_count), 32'(cnt));
    chk({tag, ".conv_start"}, 32'(conv_start), 32'(st));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".result_valid"}, 32'(result_valid), 32'(rv));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(to));
    chk({tag, ".bin_value"}, 32'(bin_value), 32'(bin));
  endtask

  task automatic step(input logic kv, input logic [3:0] kc, input logic dn, input logic [15:0] rs);
    key_valid   = kv;
    key_code    = kc;
    conv_done   = dn;
    conv_result = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    step(1'b0, 4'h0, 1'b0, 16'h0);
    step(1'b0, 4'h0, 1'b0, 16'h0);
    check_outs("reset", 16'h0, 3'd0, 0, 0, 0, 0, 0, 16'h0);
    reset = 1'b0;

    // 1,2,3,4 ENTER; stale done during START; done 3 cycles after conv_start
    tv.push_back(mk(1, 4'h1, 0, 16'h0,    16'h0001, 3'd1, 0, 0, 0, 0, 0, 16'h0));
    tv.push_back(mk(1, 4'h2, 0, 16'h0,    16'h0012, 3'd2, 0, 0, 0, 0, 0, 16'h0));
    tv.push_back(mk(1, 4'h3, 0, 16'h0,    16'h0123, 3'd3, 0, 0, 0, 0, 0, 16'h0));
    tv.push_back(mk(1, 4'h4, 0, 16'h0,    16'h1234, 3'd4, 0, 0, 0, 0, 0, 16'h0));
    tv.push_back(mk(1, 4'hA, 0, 16'h0,    16'h1234, 3'd4, 1, 1, 0, 0, 0, 16'h0));
    tv.push_back(mk(0, 4'h0, 1, 16'hBEEF, 16'h1234, 3'd4, 0, 1, 0, 0, 0, 16'h0));
    tv.push_back(mk(0, 4'h0, 0, 16'h0,    16'h1234, 3'd4, 0, 1, 0, 0, 0, 16'h0));
    tv.push_back(mk(0, 4'h0, 0, 16'h0,    16'h1234, 3'd4, 0, 1, 0, 0, 0, 16'h0));
    tv.push_back(mk(0, 4'h0, 1, 16'h04D2, 16'h0000, 3'd0, 0, 0, 1, 0, 0, 16'h04D2));
    tv.push_back(mk(0, 4'h0, 0, 16'h0,    16'h0000, 3'd0, 0, 0, 0, 0, 0, 16'h04D2));
    // 9,8,7,6,5 overflow, CLEAR, ignored code 0xD
    tv.push_back(mk(1, 4'h9, 0, 16'h0,    16'h0009, 3'd1, 0, 0, 0, 0, 0, 16'h04D2));
    tv.push_back(mk(1, 4'h8, 0, 16'h0,    16'h0098, 3'd2, 0, 0, 0, 0, 0, 16'h04D2));
    tv.push_back(mk(1, 4'h7, 0, 16'h0,    16'h0987, 3'd3, 0, 0, 0, 0, 0, 16'h04D2));
    tv.push_back(mk(1, 4'h6, 0, 16'h0,    16'h9876, 3'd4, 0, 0, 0, 0, 0, 16'h04D2));
    tv.push_back(mk(1, 4'h5, 0, 16'h0,    16'h9876, 3'd4, 0, 0, 0, 1, 0, 16'h04D2));
    tv.push_back(mk(0, 4'h0, 0, 16'h0,    16'h9876, 3'd4, 0, 0, 0, 0, 0, 16'h04D2));
    tv.push_back(mk(1, 4'hB, 0, 16'h0,    16'h0000, 3'd0, 0, 0, 0, 0, 0, 16'h04D2));
    tv.push_back(mk(1, 4'h3, 0, 16'h0,    16'h0003, 3'd1, 0, 0, 0, 0, 0, 16'h04D2));
    tv.push_back(mk(1, 4'hD, 0, 16'h0,    16'h0003, 3'd1, 0, 0, 0, 0, 0, 16'h04D2));
    tv.push_back(mk(1, 4'hB, 0, 16'h0,    16'h0000, 3'd0, 0, 0, 0, 0, 0, 16'h04D2));
    // empty ENTER, then 4,2 ENTER with keys pressed while busy
    tv.push_back(mk(1, 4'hA, 0, 16'h0,    16'h0000, 3'd0, 0, 0, 0, 0, 0, 16'h04D2));
    tv.push_back(mk(0, 4'h0, 0, 16'h0,    16'h0000, 3'd0, 0, 0, 0, 0, 0, 16'h04D2));
    tv.push_back(mk(1, 4'h4, 0, 16'h0,    16'h0004, 3'd1, 0, 0, 0, 0, 0, 16'h04D2));
    tv.push_back(mk(1, 4'h2, 0, 16'h0,    16'h0042, 3'd2, 0, 0, 0, 0, 0, 16'h04D2));
    tv.push_back(mk(1, 4'hA, 0, 16'h0,    16'h0042, 3'd2, 1, 1, 0, 0, 0, 16'h04D2));
    tv.push_back(mk(1, 4'h7, 0, 16'h0,    16'h0042, 3'd2, 0, 1, 0, 0, 0, 16'h04D2));
    tv.push_back(mk(1, 4'h7, 0, 16'h0,    16'h0042, 3'd2, 0, 1, 0, 0, 0, 16'h04D2));
    tv.push_back(mk(0, 4'h0, 1, 16'h002A, 16'h0000, 3'd0, 0, 0, 1, 0, 0, 16'h002A));
    tv.push_back(mk(0, 4'h0, 0, 16'h0,    16'h0000, 3'd0, 0, 0, 0, 0, 0, 16'h002A));
    // 1,2,3 BACKSPACE
    tv.push_back(mk(1, 4'h1, 0, 16'h0,    16'h0001, 3'd1, 0, 0, 0, 0, 0, 16'h002A));
    tv.push_back(mk(1, 4'h2, 0, 16'h0,    16'h0012, 3'd2, 0, 0, 0, 0, 0, 16'h002A));
    tv.push_back(mk(1, 4'h3, 0, 16'h0,    16'h0123, 3'd3, 0, 0, 0, 0, 0, 16'h002A));
`ifdef KEY_BACKSPACE_EN
    tv.push_back(mk(1, 4'hC, 0, 16'h0,    16'h0012, 3'd2, 0, 0, 0, 0, 0, 16'h002A));
`else
    tv.push_back(mk(1, 4'hC, 0, 16'h0,    16'h0123, 3'd3, 0, 0, 0, 0, 0, 16'h002A));
`endif
    tv.push_back(mk(1, 4'hB, 0, 16'h0,    16'h0000, 3'd0, 0, 0, 0, 0, 0, 16'h002A));
    tv.push_back(mk(1, 4'hC, 0, 16'h0,    16'h0000, 3'd0, 0, 0, 0, 0, 0, 16'h002A));
    tv.push_back(mk(1, 4'hF, 0, 16'h0,    16'h0000, 3'd0, 0, 0, 0, 0, 0, 16'h002A));

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].kv, tv[i].kc, tv[i].dn, tv[i].rs);
      check_outs($sformatf("vec%0d", i), tv[i].bcd, tv[i].cnt, tv[i].st, tv[i].bz,
                 tv[i].rv, tv[i].ov, tv[i].to, tv[i].bin);
    end

    // Timeout: 5, ENTER, converter silent
    step(1'b1, 4'h5, 1'b0, 16'h0);
    step(1'b1, 4'hA, 1'b0, 16'h0);
    chk("to.conv_start", 32'(conv_start), 32'd1);
    step(1'b0, 4'h0, 1'b0, 16'h0);
    chk("to.enter_wait_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 63; k++) begin
      step(1'b0, 4'h0, 1'b0, 16'h0);
      chk($sformatf("to.wait%0d", k), {30'd0, busy, timeout_err}, 32'h2);
    end
    step(1'b0, 4'h0, 1'b0, 16'h0);
    check_outs("to.expire", 16'h0005, 3'd1, 0, 0, 0, 0, 1, 16'h002A);
    step(1'b0, 4'h0, 1'b0, 16'h0);
    chk("to.pulse_end", 32'(timeout_err), 32'd0);

    // Re-ENTER; done arrives on the same cycle the timeout would expire
    step(1'b1, 4'hA, 1'b0, 16'h0);
    chk("retry.conv_start", 32'(conv_start), 32'd1);
    step(1'b0, 4'h0, 1'b0, 16'h0);
    for (int k = 1; k <= 63; k++) begin
      step(1'b0, 4'h0, 1'b0, 16'h0);
    end
    chk("retry.still_busy", {30'd0, busy, timeout_err}, 32'h2);
    step(1'b0, 4'h0, 1'b1, 16'h0005);
    check_outs("done_vs_to", 16'h0000, 3'd0, 0, 0, 1, 0, 0, 16'h0005);
    step(1'b0, 4'h0, 1'b0, 16'h0);
    chk("done_vs_to.rv_end", {30'd0, result_valid, timeout_err}, 32'h0);

    // Reset during WAIT, coincident with a digit strobe and a done
    step(1'b1, 4'h1, 1'b0, 16'h0);
    step(1'b1, 4'h2, 1'b0, 16'h0);
    step(1'b1, 4'hA, 1'b0, 16'h0);
    step(1'b0, 4'h0, 1'b0, 16'h0);
    chk("rst.in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    step(1'b1, 4'h9, 1'b1, 16'h7777);
    check_outs("rst.mid_conv", 16'h0, 3'd0, 0, 0, 0, 0, 0, 16'h0);
    reset = 1'b0;
    step(1'b0, 4'h0, 1'b1, 16'h1111);
    check_outs("rst.late_done", 16'h0, 3'd0, 0, 0, 0, 0, 0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_key_entry.md
Name: bcd_key_entry

Overview:
- Upstream stage of the BCD-to-binary converter in the calculator datapath.
- Collects decimal digits from the keypad decoder into a packed-BCD operand and launches a conversion on the ENTER key.
- Holds the operand stable during conversion, then captures the converter's 16-bit binary result and presents it to the ALU/operand registers with a one-cycle valid pulse.
- Adds a timeout guard so a missing converter done flag cannot hang the calculator.

Parameters:
- MAX_DIGITS, 4: maximum number of entered digits. The BCD operand is 4*MAX_DIGITS bits wide; default 16, matching the converter input.
- CONV_TIMEOUT, 64: cycles spent in WAIT before the conversion is abandoned. Must be ≥ converter worst-case latency + 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe: key_code is valid this cycle.
- key_code  in  4  key code: 0x0–0x9 digit, 0xA ENTER, 0xB CLEAR, 0xC BACKSPACE, 0xD–0xF ignored.
- bcd_word  out  4*MAX_DIGITS  packed BCD operand; most recent digit in [3:0]. Drives converter data_in.
- digit_count  out  $clog2(MAX_DIGITS+1)  number of digits currently held.
- conv_start  out  1  one-cycle start pulse to converter.
- conv_done  in  1  converter done flag, sampled as a level.
- conv_result  in  16  converter binary output.
- bin_value  out  16  last captured binary result.
- result_valid  out  1  one-cycle pulse when bin_value updates.
- busy  out  1  high in START and WAIT.
- overflow  out  1  one-cycle pulse when a digit is rejected because the buffer is full.
- timeout_err  out  1  one-cycle pulse when WAIT expires.

Behaviour:
- Reset (synchronous, active-high, wins over every other event including mid-conversion): state ENTRY; bcd_word, digit_count, bin_value, timeout counter = 0; conv_start, result_valid, busy, overflow, timeout_err = 0.
- FSM states: ENTRY, START, WAIT.
- ENTRY, key_valid with digit and digit_count < MAX_DIGITS:
  - bcd_word <= {bcd_word[4*MAX_DIGITS-5:0], key_code}
  - digit_count++
- ENTRY, key_valid with digit and digit_count == MAX_DIGITS:
  - Word unchanged.
  - overflow = 1 for the next cycle.
- ENTRY, CLEAR: bcd_word, digit_count = 0. bin_value unchanged.
- ENTRY, ENTER with digit_count == 0: ignored; no conversion.
- ENTRY, ENTER with digit_count > 0: go to START.
- ENTRY, codes 0xD–0xF: no effect. BACKSPACE behaviour is covered under Optional Feature.
- START: exactly one cycle.
  - conv_start = 1 (registered output, high during the START cycle only).
  - Next state WAIT; timeout counter cleared.
- WAIT:
  - conv_done is ignored in START and accepted only in WAIT, so a stale done from the previous operation cannot be taken.
  - On the first cycle with conv_done = 1: bin_value <= conv_result; result_valid = 1 next cycle; bcd_word, digit_count cleared; go to ENTRY.
  - If the counter reaches CONV_TIMEOUT-1 without conv_done: timeout_err = 1 next cycle; go to ENTRY. bcd_word and digit_count are retained so the user can re-press ENTER.
- bcd_word is held constant from START until WAIT exits.
- All key_valid strobes during START/WAIT are dropped; no queueing.
- busy = 1 exactly when state is START or WAIT.
- Latency:
  - ENTER key → conv_start: 1 cycle.
  - conv_done high in WAIT → result_valid/bin_value: 1 cycle.
- conv_done and timeout expiry in the same cycle: done wins; no timeout_err.
- Digit strobe and reset in the same cycle: reset wins.

Optional Feature:
- Macro: KEY_BACKSPACE_EN.
- Defined, BACKSPACE in ENTRY with digit_count > 0:
  - bcd_word <= {4'h0, bcd_word[4*MAX_DIGITS-1:4]}
  - digit_count--
- Defined, BACKSPACE with digit_count == 0: no effect.
- Undefined: 0xC is treated like 0xD–0xF (ignored); no shift-right logic is synthesized.

Test Plan:
- Keys 1,2,3,4 then ENTER; model returns conv_done with conv_result = 0x04D2 three cycles after conv_start → bcd_word = 0x1234 held through WAIT; one conv_start pulse; bin_value = 0x04D2; single result_valid pulse; digit_count = 0 afterwards.
- Keys 9,8,7,6,5 → bcd_word = 0x9876; one overflow pulse on the fifth key; digit_count = 4. Then CLEAR → bcd_word = 0x0000, count 0.
- ENTER with no digits → no conv_start, busy stays 0. Keys 4,2, ENTER; press 7 while busy → key ignored; bin_value = 0x002A after done; bcd_word = 0.
- Keys 5, ENTER; model never asserts done → timeout_err pulses CONV_TIMEOUT cycles after entering WAIT; state ENTRY; bcd_word = 0x0005 retained; second ENTER triggers a new conv_start.
- Keys 1,2, ENTER; assert reset during WAIT → next cycle all outputs 0, busy = 0; a later conv_done is ignored and result_valid stays 0.
- With KEY_BACKSPACE_EN: keys 1,2,3, BACKSPACE → bcd_word = 0x0012, count 2. Without the macro: same stimulus → bcd_word = 0x0123, count 3.
